// File: rtl/jtpang_pkg.sv
// Shared types and constants for the object-table DMA engine.
package jtpang_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCopy,
    StFlush,
    StRel
  } dma_st_e;

  localparam int unsigned OBJ_STRIDE = 4;
  localparam int unsigned OBJ_BYTES  = 128 * OBJ_STRIDE;

endpackage

// File: rtl/jtpang_objdma.sv
// Object-table DMA: copies the object table from shared object RAM into the private buffer
// while holding the Z80 off the bus. Define JTPANG_OBJDMA_VBL_EN to defer starts until vblank.
module jtpang_objdma
  import jtpang_pkg::*;
#(
  parameter int unsigned LW       = $clog2(OBJ_BYTES),
  parameter logic [11:0] SRC_BASE = 12'h000,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          dma_go,
  input  logic          LVBL,
  input  logic          busak_n,
  output logic          busrq_n,
  output logic [11:0]   src_addr,
  output logic          src_cs,
  input  logic [7:0]    src_dout,
  output logic [LW-1:0] buf_addr,
  output logic [7:0]    buf_din,
  output logic          buf_we,
  output logic          busy
);

  dma_st_e           state_q, state_d;
  logic              go_l_q;
  logic              busy_q, busy_d;
  logic              pending_q, pending_d;
  logic [LW:0]       rd_cnt_q, rd_cnt_d;
  logic [LW:0]       wr_cnt_q, wr_cnt_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic              buf_we_q, buf_we_d;
  logic [LW-1:0]     buf_addr_q, buf_addr_d;
  logic [7:0]        buf_din_q, buf_din_d;

  logic start, accept, vbl_ok, wr_fire;

  assign start  = dma_go & ~go_l_q;
  assign accept = start & ~busy_q;

`ifdef JTPANG_OBJDMA_VBL_EN
  assign vbl_ok = ~LVBL;
`else
  logic lvbl_unused;
  assign lvbl_unused = LVBL;
  assign vbl_ok      = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      go_l_q     <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      vld_q      <= '0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      go_l_q     <= dma_go;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      vld_q      <= vld_d;
      buf_we_q   <= buf_we_d;
      buf_addr_q <= buf_addr_d;
      buf_din_q  <= buf_din_d;
    end
  end

  // Starts are latched on any clk so a strobe between cens is never lost.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q | accept;
    pending_d = pending_q | accept;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    vld_d     = vld_q;
    wr_fire   = 1'b0;
    if (cen) begin
      unique case (state_q)
        StIdle: begin
          if ((pending_q | accept) && vbl_ok) begin
            state_d   = StReq;
            pending_d = 1'b0;
          end
        end
        StReq: begin
          if (!busak_n) begin
            state_d  = StCopy;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            vld_d    = '0;
          end
        end
        StCopy, StFlush: begin
          if (busak_n) begin
            // Bus lost mid-copy: drop everything in flight.
            state_d = StRel;
            vld_d   = '0;
          end else begin
            vld_d = (vld_q << 1) | RD_LAT'(state_q == StCopy);
            if (state_q == StCopy) begin
              rd_cnt_d = rd_cnt_q + 1'b1;
              if (rd_cnt_d[LW]) state_d = StFlush;
            end
            if (vld_q[RD_LAT-1]) begin
              wr_fire  = 1'b1;
              wr_cnt_d = wr_cnt_q + 1'b1;
              if (wr_cnt_d[LW]) state_d = StRel;
            end
          end
        end
        StRel: begin
          if (busak_n) begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    buf_we_d   = wr_fire;
    buf_addr_d = wr_fire ? wr_cnt_q[LW-1:0] : buf_addr_q;
    buf_din_d  = wr_fire ? src_dout : buf_din_q;
  end

  always_comb begin
    busrq_n  = !(state_q inside {StReq, StCopy, StFlush});
    src_cs   = (state_q == StCopy);
    src_addr = SRC_BASE + 12'(rd_cnt_q[LW-1:0]);
    buf_we   = buf_we_q;
    buf_addr = buf_addr_q;
    buf_din  = buf_din_q;
    busy     = busy_q;
  end

endmodule
